rs_param_station: RTL
=====================

// Module: rs_param_station
// PURPOSE
// Parametrised reservation station feeding one ALU. Holds up to RS_DEPTH dispatched ops and wakes
// operands from N_CDB broadcast buses. Issues one operand-complete op per cycle through a
// registered valid/ready port. Sits between InstFetcher dispatch and ALU, flushed by ROB clear.
// PARAMETERS
// RS_DEPTH  8   entries (power of 2, >=2)
// ROB_W     5   ROB tag width
// XLEN      32  data width
// TYPE_W    5   op-type width
// N_CDB     2   broadcast buses (ALU, LSB, ...)
// PORTS
// clk_in        in   1               clock
// rst_in        in   1               synchronous active-high reset
// rdy_in        in   1               global pause; low = hold all state
// clear_in      in   1               mispredict flush
// disp_valid    in   1               dispatch request
// disp_type     in   TYPE_W          op type
// disp_rob_id   in   ROB_W           destination ROB tag
// disp_v1/v2    in   XLEN            operand values (valid when no dep)
// disp_imm      in   XLEN            immediate
// disp_has_q1/2 in   1               operand waits on ROB tag
// disp_q1/q2    in   ROB_W           producing ROB tag
// rs_full       out  1               no free entry
// rs_count      out  $clog2(D)+1     occupied entries
// cdb_valid     in   N_CDB           per-bus broadcast valid
// cdb_rob_id    in   N_CDB*ROB_W     bus i at [i*ROB_W +: ROB_W]
// cdb_value     in   N_CDB*XLEN      bus i at [i*XLEN +: XLEN]
// iss_valid     out  1               issue slot holds op
// iss_ready     in   1               ALU accepts
// iss_type/rob_id/v1/v2/imm  out     TYPE_W/ROB_W/XLEN/XLEN/XLEN  issued op
// BEHAVIOUR
// - Reset or clear_in (rdy_in=1 for clear; reset unconditional): all entries invalid, iss_valid=0,
//   iss_* data=0, rs_count=0, rs_full=0 next cycle. Clear overrides same-cycle dispatch/issue/wakeup.
// - rdy_in=0: no state changes, CDB ignored; outputs hold.
// - rs_full = (rs_count==RS_DEPTH), from registered count. disp_valid while full: dropped, no effect.
// - Dispatch writes lowest-index free entry. Dep resolved same cycle if any cdb_valid[i] with
//   cdb_rob_id[i]==disp_qN: store that value, clear dep (same-cycle bypass, mandatory).
// - Wakeup: each cycle every valid entry compares both deps against every bus; match captures
//   value, clears dep. Multiple buses matching one tag: lowest bus index wins.
// - Entry ready = valid & !dep1 & !dep2 (registered state only; woken entry issuable next cycle).
// - Issue register loads when (!iss_valid | iss_ready) and a ready entry exists; entry freed that
//   cycle. Min dispatch-to-iss_valid latency 2 cycles (operand-complete dispatch).
// - iss_valid & !iss_ready: iss_* stable, no new load. Accept+load same cycle allowed (back-to-back).
// - Dispatch and issue same cycle: count unchanged; freed slot reusable next cycle, not same cycle.
// - rs_count updates next cycle: +disp_accepted -issued.
// CONFIGURATION
// RS_AGE_ORDER_EN defined: per-entry age field (number of older entries); new entry age=rs_count;
//   on free, entries with larger age decrement. Selection picks ready entry of smallest age.
// RS_AGE_ORDER_EN undefined: no age state; selection picks lowest-index ready entry.
// TESTING
// 1 rst_in 1 cycle mid-traffic -> iss_valid=0, rs_count=0, rs_full=0 next edge.
// 2 dispatch rob 3, v1=5,v2=7 no deps, iss_ready=1 -> iss_valid on cycle+2, rob_id=3, v1=5, v2=7.
// 3 dispatch rob 4 q1=2; two cycles later cdb_valid[1], id 2, value 0xAB -> issues next cycle, v1=0xAB.
// 4 dispatch q1=6 while cdb bus0 broadcasts id 6 val 0x11 same cycle -> no stall, v1=0x11.
// 5 fill 8 entries, iss_ready=0 -> rs_full=1; 9th dispatch dropped; clear_in -> all empty next cycle.
// 6 AGE_EN: dispatch A(rob1,dep) then B(rob2,ready) to idx0/1, wake A -> A before any later-slot op;
//   without macro: idx order, B issues first.

Source files
------------

// File: rtl/rs_param_station.sv
// rs_param_station: reservation station in front of one ALU.
//
// Holds up to RS_DEPTH dispatched ops. Operands still waiting on a ROB tag are woken by
// any of the N_CDB broadcast buses. Waking also happens on the dispatch path in the same
// cycle, so a dispatch never misses a broadcast. One operand-complete op per cycle moves
// into a registered issue slot with a valid/ready handshake. The ROB clear flushes the
// station.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global pause), clear_in (flush)
//   disp_*      dispatch request: type, ROB tag, operands, immediate, operand dependencies
//   rs_full     registered count equals RS_DEPTH
//   rs_count    occupied entries
//   cdb_*       N_CDB broadcast buses, packed. Bus i sits at slice i.
//   iss_*       registered issue slot toward the ALU. iss_ready is the ALU accept.
//
// Configuration macro: RS_AGE_ORDER_EN
//   defined   -> each entry tracks how many entries are older than it. The oldest ready
//                entry issues first.
//   undefined -> the lowest-index ready entry issues first.

module rs_param_station #(
    parameter int RS_DEPTH = 8,
    parameter int ROB_W    = 5,
    parameter int XLEN     = 32,
    parameter int TYPE_W   = 5,
    parameter int N_CDB    = 2,
    localparam int IDX_W   = $clog2(RS_DEPTH),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    disp_valid,
    input  logic [TYPE_W-1:0]       disp_type,
    input  logic [ROB_W-1:0]        disp_rob_id,
    input  logic [XLEN-1:0]         disp_v1,
    input  logic [XLEN-1:0]         disp_v2,
    input  logic [XLEN-1:0]         disp_imm,
    input  logic                    disp_has_q1,
    input  logic                    disp_has_q2,
    input  logic [ROB_W-1:0]        disp_q1,
    input  logic [ROB_W-1:0]        disp_q2,
    output logic                    rs_full,
    output logic [CNT_W-1:0]        rs_count,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]  cdb_rob_id,
    input  logic [N_CDB*XLEN-1:0]   cdb_value,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [TYPE_W-1:0]       iss_type,
    output logic [ROB_W-1:0]        iss_rob_id,
    output logic [XLEN-1:0]         iss_v1,
    output logic [XLEN-1:0]         iss_v2,
    output logic [XLEN-1:0]         iss_imm
);

    logic              ent_valid_q [RS_DEPTH];
    logic              ent_valid_d [RS_DEPTH];
    logic              ent_dep1_q  [RS_DEPTH];
    logic              ent_dep1_d  [RS_DEPTH];
    logic              ent_dep2_q  [RS_DEPTH];
    logic              ent_dep2_d  [RS_DEPTH];
    logic [ROB_W-1:0]  ent_q1_q    [RS_DEPTH];
    logic [ROB_W-1:0]  ent_q1_d    [RS_DEPTH];
    logic [ROB_W-1:0]  ent_q2_q    [RS_DEPTH];
    logic [ROB_W-1:0]  ent_q2_d    [RS_DEPTH];
    logic [XLEN-1:0]   ent_v1_q    [RS_DEPTH];
    logic [XLEN-1:0]   ent_v1_d    [RS_DEPTH];
    logic [XLEN-1:0]   ent_v2_q    [RS_DEPTH];
    logic [XLEN-1:0]   ent_v2_d    [RS_DEPTH];
    logic [XLEN-1:0]   ent_imm_q   [RS_DEPTH];
    logic [XLEN-1:0]   ent_imm_d   [RS_DEPTH];
    logic [TYPE_W-1:0] ent_type_q  [RS_DEPTH];
    logic [TYPE_W-1:0] ent_type_d  [RS_DEPTH];
    logic [ROB_W-1:0]  ent_rob_q   [RS_DEPTH];
    logic [ROB_W-1:0]  ent_rob_d   [RS_DEPTH];
`ifdef RS_AGE_ORDER_EN
    logic [IDX_W-1:0]  ent_age_q   [RS_DEPTH];
    logic [IDX_W-1:0]  ent_age_d   [RS_DEPTH];
    logic [IDX_W-1:0]  sel_age;
    logic [CNT_W-1:0]  new_age;
`endif

    logic [CNT_W-1:0]  rs_count_q, rs_count_d;
    logic              iss_valid_q, iss_valid_d;
    logic [TYPE_W-1:0] iss_type_q, iss_type_d;
    logic [ROB_W-1:0]  iss_rob_q, iss_rob_d;
    logic [XLEN-1:0]   iss_v1_q, iss_v1_d;
    logic [XLEN-1:0]   iss_v2_q, iss_v2_d;
    logic [XLEN-1:0]   iss_imm_q, iss_imm_d;

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              issue_fire;
    logic              disp_acc;
    logic              new_dep1, new_dep2;
    logic [XLEN-1:0]   new_v1, new_v2;

    assign rs_full    = (rs_count_q == CNT_W'(RS_DEPTH));
    assign rs_count   = rs_count_q;
    assign iss_valid  = iss_valid_q;
    assign iss_type   = iss_type_q;
    assign iss_rob_id = iss_rob_q;
    assign iss_v1     = iss_v1_q;
    assign iss_v2     = iss_v2_q;
    assign iss_imm    = iss_imm_q;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_valid_d[i] = ent_valid_q[i];
            ent_dep1_d[i]  = ent_dep1_q[i];
            ent_dep2_d[i]  = ent_dep2_q[i];
            ent_q1_d[i]    = ent_q1_q[i];
            ent_q2_d[i]    = ent_q2_q[i];
            ent_v1_d[i]    = ent_v1_q[i];
            ent_v2_d[i]    = ent_v2_q[i];
            ent_imm_d[i]   = ent_imm_q[i];
            ent_type_d[i]  = ent_type_q[i];
            ent_rob_d[i]   = ent_rob_q[i];
`ifdef RS_AGE_ORDER_EN
            ent_age_d[i]   = ent_age_q[i];
`endif
        end
        iss_valid_d = iss_valid_q;
        iss_type_d  = iss_type_q;
        iss_rob_d   = iss_rob_q;
        iss_v1_d    = iss_v1_q;
        iss_v2_d    = iss_v2_q;
        iss_imm_d   = iss_imm_q;

        // Issue selection looks only at registered state. An entry woken this cycle
        // therefore issues no earlier than the next cycle.
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
        sel_age   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_valid_q[i] && !ent_dep1_q[i] && !ent_dep2_q[i] &&
                (!sel_found || ent_age_q[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = ent_age_q[i];
            end
        end
`else
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ent_valid_q[i] && !ent_dep1_q[i] && !ent_dep2_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
`endif
        issue_fire = sel_found && (!iss_valid_q || iss_ready);
        disp_acc   = disp_valid && !rs_full;

        // A slot freed by this cycle's issue is still counted as occupied here.
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid_q[i]) free_idx = IDX_W'(i);
        end

        // The bus loops run in descending order so that the lowest matching bus wins.
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int b = N_CDB - 1; b >= 0; b--) begin
                if (ent_valid_q[i] && ent_dep1_q[i] && cdb_valid[b] &&
                    cdb_rob_id[b*ROB_W +: ROB_W] == ent_q1_q[i]) begin
                    ent_v1_d[i]   = cdb_value[b*XLEN +: XLEN];
                    ent_dep1_d[i] = 1'b0;
                end
                if (ent_valid_q[i] && ent_dep2_q[i] && cdb_valid[b] &&
                    cdb_rob_id[b*ROB_W +: ROB_W] == ent_q2_q[i]) begin
                    ent_v2_d[i]   = cdb_value[b*XLEN +: XLEN];
                    ent_dep2_d[i] = 1'b0;
                end
            end
        end

        new_v1   = disp_v1;
        new_v2   = disp_v2;
        new_dep1 = disp_has_q1;
        new_dep2 = disp_has_q2;
        for (int b = N_CDB - 1; b >= 0; b--) begin
            if (disp_has_q1 && cdb_valid[b] && cdb_rob_id[b*ROB_W +: ROB_W] == disp_q1) begin
                new_v1   = cdb_value[b*XLEN +: XLEN];
                new_dep1 = 1'b0;
            end
            if (disp_has_q2 && cdb_valid[b] && cdb_rob_id[b*ROB_W +: ROB_W] == disp_q2) begin
                new_v2   = cdb_value[b*XLEN +: XLEN];
                new_dep2 = 1'b0;
            end
        end

        if (issue_fire) begin
            iss_valid_d          = 1'b1;
            iss_type_d           = ent_type_q[sel_idx];
            iss_rob_d            = ent_rob_q[sel_idx];
            iss_v1_d             = ent_v1_q[sel_idx];
            iss_v2_d             = ent_v2_q[sel_idx];
            iss_imm_d            = ent_imm_q[sel_idx];
            ent_valid_d[sel_idx] = 1'b0;
`ifdef RS_AGE_ORDER_EN
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent_age_q[i] > ent_age_q[sel_idx]) ent_age_d[i] = ent_age_q[i] - 1'b1;
            end
`endif
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end

`ifdef RS_AGE_ORDER_EN
        // The new entry's age counts the older entries that survive this cycle.
        new_age = rs_count_q - {{(CNT_W-1){1'b0}}, issue_fire};
`endif
        if (disp_acc) begin
            ent_valid_d[free_idx] = 1'b1;
            ent_dep1_d[free_idx]  = new_dep1;
            ent_dep2_d[free_idx]  = new_dep2;
            ent_q1_d[free_idx]    = disp_q1;
            ent_q2_d[free_idx]    = disp_q2;
            ent_v1_d[free_idx]    = new_v1;
            ent_v2_d[free_idx]    = new_v2;
            ent_imm_d[free_idx]   = disp_imm;
            ent_type_d[free_idx]  = disp_type;
            ent_rob_d[free_idx]   = disp_rob_id;
`ifdef RS_AGE_ORDER_EN
            ent_age_d[free_idx]   = new_age[IDX_W-1:0];
`endif
        end

        rs_count_d = rs_count_q + {{(CNT_W-1){1'b0}}, disp_acc}
                                - {{(CNT_W-1){1'b0}}, issue_fire};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && clear_in)) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_valid_q[i] <= 1'b0;
                ent_dep1_q[i]  <= 1'b0;
                ent_dep2_q[i]  <= 1'b0;
                ent_q1_q[i]    <= '0;
                ent_q2_q[i]    <= '0;
                ent_v1_q[i]    <= '0;
                ent_v2_q[i]    <= '0;
                ent_imm_q[i]   <= '0;
                ent_type_q[i]  <= '0;
                ent_rob_q[i]   <= '0;
`ifdef RS_AGE_ORDER_EN
                ent_age_q[i]   <= '0;
`endif
            end
            rs_count_q  <= '0;
            iss_valid_q <= 1'b0;
            iss_type_q  <= '0;
            iss_rob_q   <= '0;
            iss_v1_q    <= '0;
            iss_v2_q    <= '0;
            iss_imm_q   <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_valid_q[i] <= ent_valid_d[i];
                ent_dep1_q[i]  <= ent_dep1_d[i];
                ent_dep2_q[i]  <= ent_dep2_d[i];
                ent_q1_q[i]    <= ent_q1_d[i];
                ent_q2_q[i]    <= ent_q2_d[i];
                ent_v1_q[i]    <= ent_v1_d[i];
                ent_v2_q[i]    <= ent_v2_d[i];
                ent_imm_q[i]   <= ent_imm_d[i];
                ent_type_q[i]  <= ent_type_d[i];
                ent_rob_q[i]   <= ent_rob_d[i];
`ifdef RS_AGE_ORDER_EN
                ent_age_q[i]   <= ent_age_d[i];
`endif
            end
            rs_count_q  <= rs_count_d;
            iss_valid_q <= iss_valid_d;
            iss_type_q  <= iss_type_d;
            iss_rob_q   <= iss_rob_d;
            iss_v1_q    <= iss_v1_d;
            iss_v2_q    <= iss_v2_d;
            iss_imm_q   <= iss_imm_d;
        end
    end

endmodule
